// File: rtl/sna_flit_parser_if.sv
// Flit and request bundle between the NoC link and the slave network adapter.
interface sna_flit_parser_if;
   logic [36:0] flit_in;
   logic        flit_valid;
   logic        flit_ready;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_src;
   logic [2:0]  req_vc;
   logic        err;
   logic [7:0]  err_cnt;

   // Parser side: consumes flits, produces requests.
   modport slave (
      input  flit_in, flit_valid, req_ready,
      output flit_ready, req_valid, req_write, req_addr, req_wdata,
             req_src, req_vc, err, err_cnt
   );

   // Environment side: drives flits, accepts requests.
   modport master (
      output flit_in, flit_valid, req_ready,
      input  flit_ready, req_valid, req_write, req_addr, req_wdata,
             req_src, req_vc, err, err_cnt
   );
endinterface

// File: rtl/sna_flit_parser.sv
// Receive-side request flit parser for the slave network adapter.
// Reassembles header/body/tail flits into a single AXI4-Lite-side request.
//
// state   | meaning
// IDLE    | waiting for a header addressed to this node
// BODY    | write header seen, waiting for the address body flit
// TAIL    | waiting for the tail (wdata for writes, address for reads)
// DISCARD | misrouted packet, swallowing flits up to its tail
// OUT     | request held on req_*, flits stalled until req_ready
module sna_flit_parser #(
   parameter logic [3:0] NODE_ADDR = 4'b0010
) (
   input logic               ACLK,
   input logic               ARESETn,
   sna_flit_parser_if.slave  bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] BODY    = 3'd1;
   localparam logic [2:0] TAIL    = 3'd2;
   localparam logic [2:0] DISCARD = 3'd3;
   localparam logic [2:0] OUT     = 3'd4;

   localparam logic [1:0] T_HDR  = 2'b10;
   localparam logic [1:0] T_BODY = 2'b00;
   localparam logic [1:0] T_TAIL = 2'b01;

   logic [2:0]  state_q, state_d;
   logic        flit_ready_q, flit_ready_d;
   logic        req_write_q, req_write_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] req_wdata_q, req_wdata_d;
   logic [3:0]  req_src_q, req_src_d;
   logic [2:0]  req_vc_q, req_vc_d;
   logic        err_q, err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic        acc;
   logic        take_hdr;
   logic [1:0]  ftype;
   logic [2:0]  fvc;
   logic [31:0] fdata;

   assign acc   = bus.flit_valid && flit_ready_q;
   assign ftype = bus.flit_in[36:35];
   assign fvc   = bus.flit_in[34:32];
   assign fdata = bus.flit_in[31:0];

   // Next-state, field capture and error accounting for each accepted flit.
   always_comb begin
      state_d     = state_q;
      req_write_d = req_write_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_src_d   = req_src_q;
      req_vc_d    = req_vc_q;
      err_d       = 1'b0;
      err_cnt_d   = err_cnt_q;
      take_hdr    = 1'b0;

      if (acc) begin
         case (state_q)
            IDLE: begin
               if (ftype == T_HDR) take_hdr = 1'b1;
               else                err_d    = 1'b1;
            end
            BODY: begin
               if (ftype == T_HDR) begin
                  err_d    = 1'b1;
                  take_hdr = 1'b1;
               end else if (ftype == T_BODY && fvc == req_vc_q) begin
                  req_addr_d = fdata;
                  state_d    = TAIL;
               end else begin
                  err_d = 1'b1;
               end
            end
            TAIL: begin
               if (ftype == T_HDR) begin
                  err_d    = 1'b1;
                  take_hdr = 1'b1;
               end else if (ftype == T_TAIL && fvc == req_vc_q) begin
                  if (req_write_q) begin
                     req_wdata_d = fdata;
                  end else begin
                     req_addr_d  = fdata;
                     req_wdata_d = 32'd0;
                  end
                  state_d = OUT;
               end else begin
                  err_d = 1'b1;
               end
            end
            DISCARD: begin
               if (ftype == T_TAIL) state_d = IDLE;
            end
            default: ;
         endcase
      end

      // A header interrupting a packet is handled exactly as one seen in IDLE;
      // a misrouted interrupting header still raises only a single err pulse.
      if (take_hdr) begin
         if (bus.flit_in[31:28] == NODE_ADDR) begin
            req_src_d   = bus.flit_in[27:24];
            req_vc_d    = fvc;
            req_write_d = ~bus.flit_in[0];
            state_d     = bus.flit_in[0] ? TAIL : BODY;
         end else begin
            err_d   = 1'b1;
            state_d = DISCARD;
         end
      end

      if (state_q == OUT && bus.req_ready) state_d = IDLE;

      if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

      flit_ready_d = (state_d != OUT);
   end

   // State and output registers; async reset drops any partial packet.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q      <= IDLE;
         flit_ready_q <= 1'b0;
         req_write_q  <= 1'b0;
         req_addr_q   <= 32'd0;
         req_wdata_q  <= 32'd0;
         req_src_q    <= 4'd0;
         req_vc_q     <= 3'd0;
         err_q        <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         flit_ready_q <= flit_ready_d;
         req_write_q  <= req_write_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_src_q    <= req_src_d;
         req_vc_q     <= req_vc_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign bus.flit_ready = flit_ready_q;
   assign bus.req_valid  = (state_q == OUT);
   assign bus.req_write  = req_write_q;
   assign bus.req_addr   = req_addr_q;
   assign bus.req_wdata  = req_wdata_q;
   assign bus.req_src    = req_src_q;
   assign bus.req_vc     = req_vc_q;
   assign bus.err        = err_q;
   assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sna_flit_parser.sv
// Directed bench for sna_flit_parser with hand-computed expectations.
module tb_sna_flit_parser;

   logic ACLK;
   logic ARESETn;
   int   checks;
   int   failures;
   int   n_req;
   int   n_err;

   sna_flit_parser_if bus ();

   sna_flit_parser #(.NODE_ADDR(4'b0010)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (bus)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Counts request handshakes and err pulses, sampled mid-cycle.
   always @(negedge ACLK) begin
      if (ARESETn) begin
         if (bus.req_valid && bus.req_ready) n_req++;
         if (bus.err) n_err++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [36:0] hdr(input logic [3:0] dest, input logic [3:0] src,
                                       input logic [2:0] vc, input logic rd);
      return {2'b10, vc, dest, src, 23'd0, rd};
   endfunction

   function automatic logic [36:0] bdy(input logic [2:0] vc, input logic [31:0] d);
      return {2'b00, vc, d};
   endfunction

   function automatic logic [36:0] tl(input logic [2:0] vc, input logic [31:0] d);
      return {2'b01, vc, d};
   endfunction

   // Presents one flit and returns #1 after the edge that accepts it.
   task automatic send(input logic [36:0] f);
      int n;
      bus.flit_in    = f;
      bus.flit_valid = 1'b1;
      n = 0;
      while (!bus.flit_ready && n < 20) begin
         @(posedge ACLK); #1;
         n++;
      end
      if (!bus.flit_ready) check("send_timeout", 64'(bus.flit_ready), 64'd1);
      @(posedge ACLK); #1;
      bus.flit_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge ACLK); #1;
      ARESETn = 1'b0;
      #1;
      check("rst_flit_ready", 64'(bus.flit_ready), 64'd0);
      check("rst_req_valid",  64'(bus.req_valid),  64'd0);
      check("rst_err_cnt",    64'(bus.err_cnt),    64'd0);
      check("rst_req_addr",   64'(bus.req_addr),   64'd0);
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      check("rel_ready_low",  64'(bus.flit_ready), 64'd0);
      @(posedge ACLK); #1;
      check("rel_ready_high", 64'(bus.flit_ready), 64'd1);
   endtask

   initial begin
      int r0, e0;
      logic [31:0] a_hold;
      checks = 0; failures = 0; n_req = 0; n_err = 0;
      ARESETn = 1'b0;
      bus.flit_in = '0; bus.flit_valid = 1'b0; bus.req_ready = 1'b1;
      #12;
      check("init_flit_ready", 64'(bus.flit_ready), 64'd0);
      check("init_req_write",  64'(bus.req_write),  64'd0);
      check("init_req_wdata",  64'(bus.req_wdata),  64'd0);
      check("init_req_src_vc", 64'({bus.req_src, bus.req_vc}), 64'd0);
      check("init_err",        64'(bus.err),        64'd0);
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      check("init_ready_up", 64'(bus.flit_ready), 64'd1);

      // Write packet
      r0 = n_req; e0 = n_err;
      send(hdr(4'd2, 4'd1, 3'd3, 1'b0));
      send(bdy(3'd3, 32'h2000_0010));
      send(tl(3'd3, 32'hDEAD_BEEF));
      check("wr_valid",  64'(bus.req_valid), 64'd1);
      check("wr_ready0", 64'(bus.flit_ready), 64'd0);
      check("wr_write",  64'(bus.req_write), 64'd1);
      check("wr_addr",   64'(bus.req_addr),  64'h2000_0010);
      check("wr_wdata",  64'(bus.req_wdata), 64'hDEAD_BEEF);
      check("wr_src",    64'(bus.req_src),   64'd1);
      check("wr_vc",     64'(bus.req_vc),    64'd3);
      @(posedge ACLK); #1;
      check("wr_valid_drop", 64'(bus.req_valid), 64'd0);
      check("wr_ready_back", 64'(bus.flit_ready), 64'd1);
      repeat (2) @(posedge ACLK); #1;
      check("wr_nreq", 64'(n_req - r0), 64'd1);
      check("wr_noerr", 64'(n_err - e0), 64'd0);

      // Read packet
      send(hdr(4'd2, 4'd4, 3'd0, 1'b1));
      send(tl(3'd0, 32'h2000_0004));
      check("rd_valid", 64'(bus.req_valid), 64'd1);
      check("rd_write", 64'(bus.req_write), 64'd0);
      check("rd_addr",  64'(bus.req_addr),  64'h2000_0004);
      check("rd_wdata", 64'(bus.req_wdata), 64'd0);
      check("rd_src",   64'(bus.req_src),   64'd4);
      @(posedge ACLK); #1;

      // Read with back-pressure
      bus.req_ready = 1'b0;
      send(hdr(4'd2, 4'd4, 3'd0, 1'b1));
      send(tl(3'd0, 32'h2000_0008));
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 64'(bus.req_valid), 64'd1);
         check("bp_ready", 64'(bus.flit_ready), 64'd0);
         check("bp_addr",  64'(bus.req_addr),  64'h2000_0008);
         check("bp_src",   64'(bus.req_src),   64'd4);
         @(posedge ACLK); #1;
      end
      bus.req_ready = 1'b1;
      @(posedge ACLK); #1;
      check("bp_release_valid", 64'(bus.req_valid), 64'd0);
      check("bp_release_ready", 64'(bus.flit_ready), 64'd1);

      // Misrouted packet then valid packet
      r0 = n_req; e0 = n_err;
      send(hdr(4'd5, 4'd1, 3'd1, 1'b0));
      check("mis_err_pulse", 64'(bus.err), 64'd1);
      send(bdy(3'd1, 32'h1111_1111));
      send(tl(3'd1, 32'h2222_2222));
      check("mis_no_valid", 64'(bus.req_valid), 64'd0);
      check("mis_err_cnt",  64'(bus.err_cnt),   64'd1);
      send(hdr(4'd2, 4'd6, 3'd2, 1'b1));
      send(tl(3'd2, 32'h3000_0000));
      check("mis_next_addr", 64'(bus.req_addr), 64'h3000_0000);
      check("mis_next_src",  64'(bus.req_src),  64'd6);
      @(posedge ACLK); #1;
      check("mis_nreq", 64'(n_req - r0), 64'd1);
      check("mis_nerr", 64'(n_err - e0), 64'd1);

      // Sequence errors
      do_reset();
      e0 = n_err;
      send(bdy(3'd3, 32'h0));
      send(hdr(4'd2, 4'd1, 3'd3, 1'b0));
      send(bdy(3'd3, 32'h4000_0000));
      send(tl(3'd6, 32'hBAD0_BAD0));
      check("seq_hold", 64'(bus.req_valid), 64'd0);
      send(tl(3'd3, 32'h1234_5678));
      check("seq_valid", 64'(bus.req_valid), 64'd1);
      check("seq_wdata", 64'(bus.req_wdata), 64'h1234_5678);
      check("seq_err_cnt", 64'(bus.err_cnt), 64'd2);
      @(posedge ACLK); #1;
      check("seq_nerr", 64'(n_err - e0), 64'd2);

      // Header interruption
      r0 = n_req; e0 = n_err;
      send(hdr(4'd2, 4'd1, 3'd1, 1'b0));
      send(hdr(4'd2, 4'd7, 3'd2, 1'b1));
      check("int_err", 64'(bus.err), 64'd1);
      send(tl(3'd2, 32'h5000_0004));
      check("int_write", 64'(bus.req_write), 64'd0);
      check("int_addr",  64'(bus.req_addr),  64'h5000_0004);
      check("int_src",   64'(bus.req_src),   64'd7);
      @(posedge ACLK); #1;
      check("int_nreq", 64'(n_req - r0), 64'd1);
      check("int_nerr", 64'(n_err - e0), 64'd1);

      // Reset mid-packet, err_cnt nonzero beforehand
      send(hdr(4'd2, 4'd3, 3'd5, 1'b0));
      send(bdy(3'd5, 32'h6000_0000));
      a_hold = bus.req_addr;
      check("mid_addr_latched", 64'(a_hold), 64'h6000_0000);
      do_reset();
      check("mid_vc_cleared", 64'(bus.req_vc), 64'd0);
      send(hdr(4'd2, 4'd9, 3'd4, 1'b0));
      send(bdy(3'd4, 32'h7000_0010));
      send(tl(3'd4, 32'hCAFE_F00D));
      check("post_addr",  64'(bus.req_addr),  64'h7000_0010);
      check("post_wdata", 64'(bus.req_wdata), 64'hCAFE_F00D);
      check("post_src",   64'(bus.req_src),   64'd9);
      @(posedge ACLK); #1;

      // Saturation
      bus.flit_in    = bdy(3'd0, 32'h0);
      bus.flit_valid = 1'b1;
      repeat (300) @(posedge ACLK);
      #1;
      check("sat_255", 64'(bus.err_cnt), 64'd255);
      repeat (5) @(posedge ACLK);
      #1;
      check("sat_hold", 64'(bus.err_cnt), 64'd255);
      check("sat_err",  64'(bus.err), 64'd1);
      bus.flit_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
